uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each completed frame (single-cycle `done`/`err` pulse plus `data`) into a first-word-fall-through FIFO and presents it to the host through a valid/ready read port. Flags overrun when the host drains too slowly. Decouples the host from the receiver's one-cycle result pulses.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_ram.sv | 27 ++
 rtl/uart_rx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: FIFO depth default, byte/entry widths, receiver baud ticks.
// Optional feature macro: UART_RX_FIFO_FERR_EN (store framing-error frames with a ferr tag bit).
package uart_pkg;

  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_DATA_W        = 8;

`ifdef UART_RX_FIFO_FERR_EN
  // Entry carries {ferr, byte} so the host can see which bytes were corrupt.
  localparam int UART_RX_ENTRY_W = UART_DATA_W + 1;
`else
  localparam int UART_RX_ENTRY_W = UART_DATA_W;
`endif

  // Receiver baud timing: full-bit and half-bit (mid-sample) tick counts.
  localparam int UART_BAUD_TICKS      = 10416;
  localparam int UART_BAUD_HALF_TICKS = 5208;

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the RX FIFO: one synchronous write port,
// one asynchronous read port, contents never reset.
module uart_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Capture the incoming entry at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: captures one-cycle receiver result pulses into a
// first-word-fall-through FIFO with a valid/ready host read port, plus sticky
// overflow and framing-error flags.
// Optional feature macro: UART_RX_FIFO_FERR_EN (error frames are stored and tagged).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_done,
  input  logic                   rx_err,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_ferr,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   overflow,
  output logic                   frame_err,
  input  logic                   clr_flags
);

  // One extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]                  wptr_r;
  logic [AW:0]                  rptr_r;
  logic                         overflow_r;
  logic                         frame_err_r;
  logic                         wr_req_s;
  logic                         pop_s;
  logic                         full_s;
  logic                         empty_s;
  logic                         wr_en_s;
  logic                         ovf_set_s;
  logic [UART_RX_ENTRY_W-1:0]   wr_entry_s;
  logic [UART_RX_ENTRY_W-1:0]   rd_entry_s;

  // Write request and entry formatting; rx_done with rx_err counts as an error frame.
  always_comb begin
`ifdef UART_RX_FIFO_FERR_EN
    wr_req_s   = rx_done | rx_err;
    wr_entry_s = {rx_err, rx_data};
`else
    wr_req_s   = rx_done & ~rx_err;
    wr_entry_s = rx_data;
`endif
  end

  // Occupancy status is derived only from the registered pointers.
  always_comb begin
    empty_s   = (wptr_r == rptr_r);
    full_s    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    pop_s     = ~empty_s & rd_ready;
    wr_en_s   = wr_req_s & (~full_s | pop_s) & ~rst;
    ovf_set_s = wr_req_s & full_s & ~pop_s;
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (UART_RX_ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wptr_r[AW-1:0]),
    .wdata (wr_entry_s),
    .raddr (rptr_r[AW-1:0]),
    .rdata (rd_entry_s)
  );

  // Pointer advance; reset discards every entry and any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wptr_r <= wptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + (AW+1)'(1);
      end
    end
  end

  // Sticky flags: a set event in the same cycle as clr_flags keeps the flag high.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_flags) begin
        overflow_r <= 1'b0;
      end
      if (rx_err) begin
        frame_err_r <= 1'b1;
      end else if (clr_flags) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  // Host-facing view of the head entry.
  always_comb begin
    rd_data = rd_entry_s[UART_DATA_W-1:0];
`ifdef UART_RX_FIFO_FERR_EN
    rd_ferr = rd_entry_s[UART_DATA_W];
`else
    rd_ferr = 1'b0;
`endif
  end

  assign rd_valid  = ~empty_s;
  assign count     = wptr_r - rptr_r;
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected entries are queued when frames
// are driven and compared when the host pops them; status is compared every cycle.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_done;
  logic        rx_err;
  logic [7:0]  rx_data;
  logic        rd_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ferr;
  logic [AW:0] count;
  logic        full;
  logic        overflow;
  logic        frame_err;
  logic        clr_flags;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [8:0] sb_q[$];
  bit         ovf_m;
  bit         fe_m;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rx_data   (rx_data),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ferr   (rd_ferr),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check_eq("rd_valid", 32'(rd_valid), 32'(sb_q.size() > 0));
    check_eq("count", 32'(count), 32'(sb_q.size()));
    check_eq("full", 32'(full), 32'(sb_q.size() == DEPTH));
    check_eq("overflow", 32'(overflow), 32'(ovf_m));
    check_eq("frame_err", 32'(frame_err), 32'(fe_m));
    if (sb_q.size() > 0) begin
      check_eq("head_data", 32'(rd_data), 32'(sb_q[0][7:0]));
`ifdef UART_RX_FIFO_FERR_EN
      check_eq("head_ferr", 32'(rd_ferr), 32'(sb_q[0][8]));
`else
      check_eq("head_ferr", 32'(rd_ferr), 32'd0);
`endif
    end
  endtask

  // One clock of stimulus; the model is updated with the same rules the host sees.
  task automatic cyc(input bit d, input bit e, input logic [7:0] dat, input bit rdy, input bit clr);
    bit wr;
    bit pop;
    bit full_m;
    rx_done   = d;
    rx_err    = e;
    rx_data   = dat;
    rd_ready  = rdy;
    clr_flags = clr;
    pop    = rdy && (sb_q.size() > 0);
    full_m = (sb_q.size() == DEPTH);
`ifdef UART_RX_FIFO_FERR_EN
    wr = d | e;
`else
    wr = d & !e;
`endif
    if (pop) begin
      check_eq("pop_data", 32'(rd_data), 32'(sb_q[0][7:0]));
      void'(sb_q.pop_front());
    end
    if (wr && (!full_m || pop)) sb_q.push_back({e, dat});
    if (wr && full_m && !pop) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    if (e) fe_m = 1'b1;
    else if (clr) fe_m = 1'b0;
    @(posedge clk);
    #1;
    rx_done   = 1'b0;
    rx_err    = 1'b0;
    rd_ready  = 1'b0;
    clr_flags = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input bit d);
    rst     = 1'b1;
    rx_done = d;
    rx_data = 8'hEE;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rx_done = 1'b0;
    sb_q.delete();
    ovf_m = 1'b0;
    fe_m  = 1'b0;
    check_state();
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (sb_q.size() > 0) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    rd_ready = 1'b0; clr_flags = 1'b0;
    #1;
    do_reset(1'b0);
    do_reset(1'b0);

    // Single byte: visible next cycle, gone after one pop.
    cyc(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    check_eq("a5_data", 32'(rd_data), 32'h0000_00A5);
    check_eq("a5_count", 32'(count), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("a5_empty", 32'(rd_valid), 32'd0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_count", 32'(count), 32'd16);
    cyc(1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    drain();
    check_eq("drained", 32'(rd_valid), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous write and pop: accepted, count unchanged.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    check_eq("fullpop_count", 32'(count), 32'd16);
    check_eq("fullpop_ovf", 32'(overflow), 32'd0);
    drain();

    // Framing error frame.
    cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    check_eq("ferr_flag", 32'(frame_err), 32'd1);
    drain();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Clear colliding with an overflowing write keeps the flag; clear alone drops it.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
    check_eq("clr_collide", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("clr_alone", 32'(overflow), 32'd0);
    drain();

    // Streaming write+pop across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b1, 1'b0);
      check_eq("stream_le1", 32'(count <= 1), 32'd1);
    end
    drain();

    // Reset mid-stream with a same-cycle frame.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    do_reset(1'b1);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_valid", 32'(rd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
